// File: rtl/uart_pkg.sv
// Purpose : shared types and helpers for the UART transmit path (and the future RX path).
// Latency : n/a (types, constants and a constant function only).
// Backpr. : n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Width of the baud phase accumulator. It must hold acc + BAUD, and acc
    // stays below clk_hz, so clk_hz + baud is the largest value it ever sees.
    function automatic int baud_acc_w(input longint clk_hz, input longint baud);
        return $clog2(clk_hz + baud) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Purpose : single-clock FIFO, read data presented combinationally at the read pointer.
// Latency : a push is visible on empty_o/count_o the cycle after the push edge.
// Backpr. : full_o derived from registered count; pushes while full and pops while empty are ignored.
//
// Ports:
//   clk_i, rstn_i          clock, synchronous active-low reset (clears pointers and count)
//   push_i, wdata_i, full_o   write side
//   pop_i, rdata_o, empty_o   read side; rdata_o is the head word whenever !empty_o
//   count_o                words currently stored (0..DEPTH)
module uart_sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Purpose : UART transmitter, 5..8 data bits LSB first, optional parity, 1 or 2 stop bits, input FIFO.
// Latency : word accepted at edge E into an idle, empty block drives the start bit from edge E+1.
// Backpr. : tx_ready_o = FIFO not full (registered count); frames go out back-to-back while queued.
//
// Ports:
//   sys_clk_i, sys_rstn_i   clock, synchronous active-low reset
//   tx_valid_i, tx_data_i   producer word, accepted when tx_valid_i && tx_ready_o
//   tx_ready_o              FIFO has room
//   fifo_count_o            words queued, not counting the frame on the line
//   busy_o                  a frame is in progress
//   uart_tx_o               registered serial line, idle high
module uart_tx_param
    import uart_pkg::*;
#(
    parameter  int unsigned CLK_HZ     = 100_000_000,
    parameter  int unsigned BAUD       = 115200,
    parameter  int unsigned DATA_BITS  = 8,
    parameter  parity_e     PARITY     = PARITY_NONE,
    parameter  int unsigned STOP_BITS  = 1,
    parameter  int unsigned FIFO_DEPTH = 16,
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_rstn_i,
    input  logic                 tx_valid_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    output logic                 tx_ready_o,
    output logic [CNT_W-1:0]     fifo_count_o,
    output logic                 busy_o,
    output logic                 uart_tx_o
);

    if (CLK_HZ < 4 * BAUD) begin : g_bad_baud
        $error("uart_tx_param: CLK_HZ must be at least 4*BAUD");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
        $error("uart_tx_param: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    localparam int unsigned            ACC_W      = baud_acc_w(CLK_HZ, BAUD);
    localparam logic [ACC_W-1:0]       ACC_CLK    = ACC_W'(CLK_HZ);
    localparam logic [ACC_W-1:0]       ACC_BAUD   = ACC_W'(BAUD);
    localparam logic [2:0]             LAST_DATA  = 3'(DATA_BITS - 1);
    localparam logic [2:0]             LAST_STOP  = 3'(STOP_BITS - 1);
    localparam bit                     HAS_PARITY = (PARITY != PARITY_NONE);

    // ---------------------------------------------------------------- FIFO
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic [CNT_W-1:0]     fifo_count;

    assign fifo_push = tx_valid_i && !fifo_full;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk_i),
        .rstn_i  (sys_rstn_i),
        .push_i  (fifo_push),
        .wdata_i (tx_data_i),
        .full_o  (fifo_full),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign tx_ready_o   = !fifo_full;
    assign fifo_count_o = fifo_count;

    // ---------------------------------------------------------------- state
    tx_state_e            state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 line_q, line_d;

    logic [ACC_W-1:0]     acc_sum;
    logic                 tick;
    logic                 load_par;

    // Fractional baud: a tick each time the phase wraps past CLK_HZ, so bit
    // lengths alternate between floor and ceil of CLK_HZ/BAUD.
    assign acc_sum = acc_q + ACC_BAUD;
    assign tick    = (acc_sum >= ACC_CLK);

    assign load_par = (PARITY == PARITY_ODD) ? ~(^fifo_rdata) : (^fifo_rdata);

    // The line is registered, so line_d is the value for the state being
    // entered, not the current one.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        line_d    = line_q;
        fifo_pop  = 1'b0;

        if (state_q == IDLE) begin
            acc_d = '0;
        end else if (tick) begin
            acc_d = acc_sum - ACC_CLK;
        end else begin
            acc_d = acc_sum;
        end

        case (state_q)
            IDLE: begin
                line_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    par_d    = load_par;
                    state_d  = START;
                    line_d   = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    line_d    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (HAS_PARITY) begin
                            // The state literal is qualified: the parameter of the same name hides it.
                            state_d = uart_pkg::PARITY;
                            line_d  = par_q;
                        end else begin
                            state_d = STOP;
                            line_d  = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        line_d    = shift_q[1];
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (tick) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                    line_d    = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        if (!fifo_empty) begin
                            // Chain straight into the next start bit; the
                            // accumulator keeps its phase across frames.
                            fifo_pop = 1'b1;
                            shift_d  = fifo_rdata;
                            par_d    = load_par;
                            state_d  = START;
                            line_d   = 1'b0;
                        end else begin
                            state_d = IDLE;
                            line_d  = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            line_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            line_q    <= line_d;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign uart_tx_o = line_q;

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with an input FIFO and a valid/ready byte interface. It serialises 5–8-bit words, LSB first, with optional parity and one or two stop bits. Bit timing comes from a fractional phase-accumulator baud generator. It sits between any on-chip producer (core MMIO store path, debug logger) and the board TX pin, and replaces the fixed 8N1 fire-and-forget transmitter.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BAUD, 115200, line rate; must satisfy CLK_HZ >= 4*BAUD (elaboration assertion)
- DATA_BITS, 8, word width, legal 5..8
- PARITY, PARITY_NONE, one of PARITY_NONE / PARITY_ODD / PARITY_EVEN
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 16, power of two, >= 2

Ports:
- sys_clk_i  in  1  system clock; one clock domain only
- sys_rstn_i  in  1  reset, synchronous, active-low
- tx_valid_i  in  1  producer has a word
- tx_data_i  in  DATA_BITS  word to send
- tx_ready_o  out  1  FIFO can accept; = (count != FIFO_DEPTH)
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  words currently queued
- busy_o  out  1  high whenever the FSM is not IDLE
- uart_tx_o  out  1  serial line, idle high, registered

## Operation
- Push: a word is written on any rising edge where tx_valid_i && tx_ready_o. Pushes never drop data and never overflow.
- Pop: the FSM pops exactly once per frame, on the edge where it leaves IDLE, or leaves STOP, with the FIFO non-empty.
- Same-edge push and pop: count is unchanged and both take effect.
- FSM states and line values:
  - IDLE: line 1.
  - START: line 0.
  - DATA: line = shifter[0]; the shifter shifts right each bit; runs DATA_BITS bits.
  - PARITY: only when PARITY != NONE.
  - STOP: line 1, lasts STOP_BITS bits.
- FSM transitions:
  - IDLE -> START when count != 0.
  - START -> DATA -> (PARITY) -> STOP.
  - STOP -> START directly if count != 0 at its last tick, so there is no idle gap between frames. Otherwise STOP -> IDLE.
- Parity:
  - EVEN: parity bit = XOR of the data bits.
  - ODD: parity bit = inverted XOR of the data bits.
  - Computed from the popped word at load time.
- Frame length = 1 + DATA_BITS + (PARITY != NONE) + STOP_BITS bit periods.
- Baud generator:
  - Accumulator is $clog2(CLK_HZ+BAUD)+1 bits, unsigned.
  - Each cycle: acc + BAUD >= CLK_HZ gives tick = 1 and acc <= acc + BAUD - CLK_HZ; otherwise acc <= acc + BAUD.
  - Accumulator is cleared to 0 while in IDLE and on the edge entering START from IDLE.
  - It runs continuously across back-to-back frames.
- Each bit period ends on a tick. Average bit length is CLK_HZ/BAUD cycles; any single bit is floor or ceil of that.

## Timing
- Reset values, on the first edge with sys_rstn_i low:
  - uart_tx_o = 1, busy_o = 0, fifo_count_o = 0, tx_ready_o = 1
  - FSM in IDLE, accumulator = 0, FIFO pointers = 0
- Reset mid-frame: the line returns high on that edge and queued words are discarded. No partial frame resumes.
- Latency: a word accepted at edge E into an empty, idle block makes uart_tx_o fall at edge E+1, with busy_o rising at E+1.
- tx_ready_o and fifo_count_o are derived only from registered count, with no combinational path from tx_valid_i.
- FIFO full: tx_ready_o deasserts the cycle after the filling push. It reasserts the cycle after the next pop.
- FIFO empty at the end of STOP: busy_o falls on the same edge the FSM enters IDLE. uart_tx_o stays 1.

## Structure
- Package uart_pkg holds:
  - parity_e (PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2)
  - tx_state_e (IDLE, START, DATA, PARITY, STOP)
  - function baud_acc_w(clk_hz, baud) returning the accumulator width
- Sub-module uart_sync_fifo:
  - parameters WIDTH, DEPTH
  - ports push/wdata/full, pop/rdata/empty, count
  - rdata is valid combinationally from the read pointer, so the FSM loads it on the pop edge.
  - The same FIFO is reused by the future RX block.
- Baud generator and FSM are inline in uart_tx_param.

## Test plan
- Reset: hold sys_rstn_i low for 3 cycles mid-frame -> uart_tx_o = 1, busy_o = 0, fifo_count_o = 0, tx_ready_o = 1 after the first low edge; no further line activity.
- 8N1 with CLK_HZ=1_000_000, BAUD=100_000, push 0xA5 -> line falls 1 cycle after accept. Expected line: 0 for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for 10 cycles; busy_o is high for exactly 100 cycles.
- Parity, same clock and baud, 0x07:
  - EVEN -> parity bit = 1 and frame = 110 cycles.
  - ODD -> parity bit = 0.
  - DATA_BITS=7 with STOP_BITS=2 -> frame = 110 cycles.
- Backpressure, FIFO_DEPTH=4, tx_valid_i held with 6 words -> exactly 5 words accepted before tx_ready_o falls. tx_ready_o rises 1 cycle after the second frame's start. All 6 frames go out back-to-back with no idle cycle and the data in order.
- Fractional baud, CLK_HZ=100_000_000, BAUD=115200, 10 frames of 0x55 back-to-back -> total busy time 86806 ±1 cycles; every bit is 868 or 869 cycles.
